// File: rtl/z_result_sequencer.sv
// z_result_sequencer: sequences ALU ops through the 64-bit Z register
// and moves its halves onto the bus into Rin or LO/HI.
module z_result_sequencer #(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] op_class,
  input  logic       abort,
  output logic       ready,
  output logic       alu_start,
  output logic       ZIn,
  output logic       ZLowSelect,
  output logic       ZHighSelect,
  output logic       ZLowOut,
  output logic       ZHighOut,
  output logic       Rin,
  output logic       LOin,
  output logic       HIin,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, EXEC, LDZL, LDZH, XLO, XHI, DONE, ERR} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, r_top, w_n1;
  logic             r_wide, w_accept;
  assign w_n1 = op_class == 2'b01 ? CNT_W'(MUL_CYCLES - 1) :
                op_class == 2'b10 ? CNT_W'(DIV_CYCLES - 1) : '0;
  assign w_accept = r_state == IDLE && start && op_class != 2'b11;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_top   <= '0;
      r_wide  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= w_n1;
        r_top  <= w_n1;
        r_wide <= op_class != 2'b00;
      end else if (r_state == EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  // abort wins over every transition except in IDLE/DONE/ERR
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = op_class == 2'b11 ? ERR : EXEC;
      EXEC:    if (r_cnt == '0) w_next = LDZL;
      LDZL:    w_next = r_wide ? LDZH : XLO;
      LDZH:    w_next = XLO;
      XLO:     w_next = r_wide ? XHI : DONE;
      XHI:     w_next = DONE;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && !(r_state inside {IDLE, DONE, ERR})) w_next = IDLE;
  end
  assign ready       = r_state == IDLE;
  assign alu_start   = r_state == EXEC && r_cnt == r_top;
  assign ZIn         = r_state == LDZL || r_state == LDZH;
  assign ZLowSelect  = r_state == LDZL;
  assign ZHighSelect = r_state == LDZH;
  assign ZLowOut     = r_state == XLO;
  assign ZHighOut    = r_state == XHI;
  assign Rin         = r_state == XLO && !r_wide;
  assign LOin        = r_state == XLO && r_wide;
  assign HIin        = r_state == XHI;
  assign done        = r_state == DONE;
  assign err         = r_state == ERR;
endmodule

// File: tb/tb_z_result_sequencer.sv
// tb_z_result_sequencer: per-cycle output scoreboard fed by a schedule-level
// reference model; directed scenarios followed by random traffic.
module tb_z_result_sequencer;
  localparam int MUL = 32;
  localparam int DIV = 3;
  // vector layout: ready alu_start ZIn ZLsel ZHsel ZLout ZHout Rin LOin HIin done err
  localparam logic [11:0] V_IDLE = 12'h800, V_ALU = 12'h400, V_LDZL = 12'h300,
                          V_LDZH = 12'h280, V_XLO_W = 12'h048, V_XLO_N = 12'h050,
                          V_XHI = 12'h024, V_DONE = 12'h002, V_ERR = 12'h001;
  logic clk = 1'b0, clr = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] op_class = 2'b00;
  logic ready, alu_start, ZIn, ZLowSelect, ZHighSelect, ZLowOut, ZHighOut;
  logic Rin, LOin, HIin, done, err;
  logic [11:0] got, cur = V_IDLE;
  logic [11:0] q[$];
  int checks = 0, errors = 0, cyc = 0;

  z_result_sequencer #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
    .clk(clk), .clr(clr), .start(start), .op_class(op_class), .abort(abort),
    .ready(ready), .alu_start(alu_start), .ZIn(ZIn), .ZLowSelect(ZLowSelect),
    .ZHighSelect(ZHighSelect), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
    .Rin(Rin), .LOin(LOin), .HIin(HIin), .done(done), .err(err));

  always #5 clk = ~clk;
  assign got = {ready, alu_start, ZIn, ZLowSelect, ZHighSelect, ZLowOut, ZHighOut,
                Rin, LOin, HIin, done, err};

  function automatic void push_op(input logic [1:0] oc);
    int n;
    bit w;
    if (oc == 2'b11) begin
      q.push_back(V_ERR);
      return;
    end
    n = oc == 2'b00 ? 1 : oc == 2'b01 ? MUL : DIV;
    w = oc != 2'b00;
    q.push_back(V_ALU);
    for (int i = 1; i < n; i++) q.push_back(12'h000);
    q.push_back(V_LDZL);
    if (w) q.push_back(V_LDZH);
    q.push_back(w ? V_XLO_W : V_XLO_N);
    if (w) q.push_back(V_XHI);
    q.push_back(V_DONE);
  endfunction

  // reference model: schedules the whole response when an op is accepted
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      if (cur == V_IDLE && start) push_op(op_class);
      else if (abort && cur != V_IDLE && cur != V_DONE && cur != V_ERR) q.delete();
    end
  end

  always @(negedge clk) begin
    cur = q.size() > 0 ? q.pop_front() : V_IDLE;
    checks++;
    if (got !== cur) begin
      errors++;
      $display("FAIL outputs cyc=%0d got=%03h exp=%03h", cyc, got, cur);
    end
  end

  always @(negedge clr) begin
    q.delete();
    cur = V_IDLE;
    #1;
    checks++;
    if (got !== V_IDLE) begin
      errors++;
      $display("FAIL async_reset got=%03h exp=%03h", got, V_IDLE);
    end
  end

  task automatic step(input logic s, input logic [1:0] oc, input logic a);
    start = s;
    op_class = oc;
    abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    #2 clr = 1'b0;
    #21 clr = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 2'b00, 1'b0); idle(6);
    step(1'b1, 2'b01, 1'b0); idle(40);
    step(1'b1, 2'b10, 1'b0); idle(1); step(1'b1, 2'b00, 1'b0); idle(10);
    step(1'b1, 2'b01, 1'b0); idle(9); step(1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b00, 1'b0); idle(6);
    step(1'b1, 2'b10, 1'b0); step(1'b0, 2'b00, 1'b1); idle(4);
    step(1'b1, 2'b11, 1'b0); step(1'b0, 2'b00, 1'b1); idle(3);
    step(1'b1, 2'b01, 1'b1); idle(40);
    step(1'b1, 2'b00, 1'b0); idle(3); step(1'b0, 2'b00, 1'b1); idle(3);
    step(1'b1, 2'b01, 1'b0); idle(5);
    #3 clr = 1'b0;
    #12 clr = 1'b1;
    @(posedge clk);
    #1;
    idle(40);
    for (int i = 0; i < 600; i++)
      step($urandom_range(2) == 0, 2'($urandom_range(3)), $urandom_range(24) == 0);
    idle(45);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
